// File: rtl/retune_sequencer.sv
// Retune sequencer: mutes the sample stream, applies a new NCO/CIC/FIR config, discards settle samples.
// Optional drop counter port drop_cnt_o is built when RETUNE_DROP_CNT_EN is defined.
module retune_sequencer #(
  parameter int SETTLE_SAMPLES = 8,
  parameter int MAX_RATE_DIV   = 5,
  parameter int SAMPLE_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             cfg_i,
  input  logic [31:0]             phi_inc_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_data_i,
  input  logic                    sample_valid_i,
  input  logic                    sample_ready_i,
  output logic [31:0]             phi_inc_o,
  output logic [3:0]              cic_rate_div_o,
  output logic [4:0]              cic_out_gain_o,
  output logic [4:0]              fir_out_gain_o,
  output logic [7:0]              led_o,
  output logic [SAMPLE_WIDTH-1:0] sample_data_o,
  output logic                    sample_valid_o,
  output logic                    busy_o
`ifdef RETUNE_DROP_CNT_EN
  ,
  output logic [15:0]             drop_cnt_o
`endif
);

  localparam int CW = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
  localparam logic [3:0] MAX_RD = 4'(MAX_RATE_DIV);

  typedef enum logic [1:0] {MUTE, APPLY, SETTLE, RUN} state_t;

  typedef struct packed {
    logic [4:0] fir_gain;
    logic [4:0] cic_gain;
    logic [3:0] rate_req;
  } tune_cfg_t;

  state_t          state;
  logic [3:0]      rate_req;
  logic [CW-1:0]   cnt;
  logic            change;
  tune_cfg_t       req_cfg;
  tune_cfg_t       cur_cfg;

  // Rate divider is compared pre-clamp so re-driving an out-of-range value is not a change.
  assign req_cfg = tune_cfg_t'(cfg_i[21:8]);
  assign cur_cfg = '{fir_gain: fir_out_gain_o, cic_gain: cic_out_gain_o, rate_req: rate_req};
  assign change  = (req_cfg != cur_cfg) || (phi_inc_i != phi_inc_o);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= MUTE;
      busy_o         <= 1'b1;
      phi_inc_o      <= '0;
      cic_rate_div_o <= '0;
      cic_out_gain_o <= '0;
      fir_out_gain_o <= '0;
      rate_req       <= '0;
      cnt            <= '0;
    end else begin
      case (state)
        RUN: begin
          if (change) begin
            state  <= MUTE;
            busy_o <= 1'b1;
          end
        end
        MUTE: begin
          state  <= APPLY;
          busy_o <= 1'b1;
        end
        APPLY: begin
          phi_inc_o      <= phi_inc_i;
          cic_out_gain_o <= req_cfg.cic_gain;
          fir_out_gain_o <= req_cfg.fir_gain;
          rate_req       <= req_cfg.rate_req;
          cic_rate_div_o <= (req_cfg.rate_req > MAX_RD) ? MAX_RD : req_cfg.rate_req;
          cnt            <= CW'(SETTLE_SAMPLES);
          state          <= SETTLE;
          busy_o         <= 1'b1;
        end
        SETTLE: begin
          if (change) begin
            state  <= MUTE;
            busy_o <= 1'b1;
          end else if (cnt == '0) begin
            state  <= RUN;
            busy_o <= 1'b0;
          end else if (sample_valid_i) begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= MUTE;
          busy_o <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_o          <= '0;
      sample_data_o  <= '0;
      sample_valid_o <= 1'b0;
    end else begin
      led_o          <= cfg_i[7:0];
      sample_data_o  <= sample_data_i;
      sample_valid_o <= sample_valid_i && (state == RUN);
    end
  end

`ifdef RETUNE_DROP_CNT_EN
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  // A gated input and a forwarded-but-unaccepted output can both happen in one cycle.
  assign drop_inc = 2'(sample_valid_i && (state != RUN)) + 2'(sample_valid_o && !sample_ready_i);
  assign drop_sum = {1'b0, drop_cnt_o} + 17'(drop_inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt_o <= '0;
    else       drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  logic unused_cfg;
  assign unused_cfg = ^cfg_i[31:22];
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_i[31:22], sample_ready_i};
`endif

endmodule

// File: tb/tb_retune_sequencer.sv
// Randomized bench for retune_sequencer against a phase-level reference model.
module tb_retune_sequencer;
  localparam int SW = 32;
  localparam int S_SAMPLES = 8;
  localparam int MAXR = 5;
  localparam int P_RUN = 0, P_MUTE = 1, P_APPLY = 2, P_SETTLE = 3;

  logic          clk = 0;
  logic          reset;
  logic [31:0]   cfg_i, phi_inc_i;
  logic [SW-1:0] sample_data_i;
  logic          sample_valid_i, sample_ready_i;
  logic [31:0]   phi_inc_o;
  logic [3:0]    cic_rate_div_o;
  logic [4:0]    cic_out_gain_o, fir_out_gain_o;
  logic [7:0]    led_o;
  logic [SW-1:0] sample_data_o;
  logic          sample_valid_o, busy_o;
`ifdef RETUNE_DROP_CNT_EN
  logic [15:0]   drop_cnt_o;
`endif

  retune_sequencer dut (
    .clk(clk), .reset(reset), .cfg_i(cfg_i), .phi_inc_i(phi_inc_i),
    .sample_data_i(sample_data_i), .sample_valid_i(sample_valid_i), .sample_ready_i(sample_ready_i),
    .phi_inc_o(phi_inc_o), .cic_rate_div_o(cic_rate_div_o), .cic_out_gain_o(cic_out_gain_o),
    .fir_out_gain_o(fir_out_gain_o), .led_o(led_o), .sample_data_o(sample_data_o),
    .sample_valid_o(sample_valid_o), .busy_o(busy_o)
`ifdef RETUNE_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int tick = 0;

  // Reference model: phase, applied config, settle samples still to discard.
  int          m_ph, m_left, m_drop;
  logic [31:0] m_phi;
  int          m_rate_raw, m_rate, m_cic, m_fir;
  logic [7:0]  m_led;
  logic [SW-1:0] m_data;
  logic        m_vout, m_busy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = P_MUTE; m_left = 0; m_drop = 0; m_phi = 0;
    m_rate_raw = 0; m_rate = 0; m_cic = 0; m_fir = 0;
    m_led = 0; m_data = 0; m_vout = 0; m_busy = 1;
  endtask

  function automatic bit model_change();
    return (int'(cfg_i[11:8]) != m_rate_raw) || (int'(cfg_i[16:12]) != m_cic) ||
           (int'(cfg_i[21:17]) != m_fir) || (phi_inc_i != m_phi);
  endfunction

  task automatic model_step();
    int  nxt;
    bit  running;
    running = (m_ph == P_RUN);
    nxt = m_ph;
    if (m_ph == P_MUTE) nxt = P_APPLY;
    else if (m_ph == P_APPLY) begin
      m_phi = phi_inc_i;
      m_rate_raw = int'(cfg_i[11:8]);
      m_rate = (m_rate_raw > MAXR) ? MAXR : m_rate_raw;
      m_cic = int'(cfg_i[16:12]);
      m_fir = int'(cfg_i[21:17]);
      m_left = S_SAMPLES;
      nxt = P_SETTLE;
    end else if (model_change()) nxt = P_MUTE;
    else if (m_ph == P_SETTLE) begin
      if (m_left == 0) nxt = P_RUN;
      else if (sample_valid_i) m_left--;
    end
    m_drop += int'(sample_valid_i && !running) + int'(m_vout && !sample_ready_i);
    if (m_drop > 65535) m_drop = 65535;
    m_vout = sample_valid_i && running;
    m_data = sample_data_i;
    m_led  = cfg_i[7:0];
    m_ph   = nxt;
    m_busy = (nxt != P_RUN);
  endtask

  task automatic check_all();
    chk("phi_inc", phi_inc_o, m_phi);
    chk("rate_div", cic_rate_div_o, 4'(m_rate));
    chk("cic_gain", cic_out_gain_o, 5'(m_cic));
    chk("fir_gain", fir_out_gain_o, 5'(m_fir));
    chk("led", led_o, m_led);
    chk("data", sample_data_o, m_data);
    chk("valid", sample_valid_o, m_vout);
    chk("busy", busy_o, m_busy);
`ifdef RETUNE_DROP_CNT_EN
    chk("drop_cnt", drop_cnt_o, 16'(m_drop));
`endif
  endtask

  // Inputs are stable across the rising edge; outputs are checked on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    tick++;
  endtask

  task automatic run(input int n, input int vper);
    for (int i = 0; i < n; i++) begin
      sample_valid_i = (tick % vper) == 0;
      sample_data_i  = $urandom;
      cfg_i[7:0]     = 8'($urandom);
      cycle();
    end
  endtask

  task automatic wait_phase(input int ph, input int cnt_val, input string tag);
    int k;
    k = 0;
    while (!(m_ph == ph && (cnt_val < 0 || m_left == cnt_val)) && k < 300) begin
      run(1, 4);
      k++;
    end
    chk(tag, 64'(k < 300), 64'd1);
  endtask

  initial begin
    reset = 1;
    cfg_i = 32'h0000_3500; phi_inc_i = 32'h0100_0000;
    sample_data_i = 0; sample_valid_i = 0; sample_ready_i = 1;
    model_reset();
    #2;
    check_all();
    @(negedge clk); @(negedge clk);
    reset = 0;

    // Initial config goes through the full sequence.
    run(60, 4);
    chk("init_rate5", cic_rate_div_o, 4'd5);
    chk("init_cic3", cic_out_gain_o, 5'd3);
    chk("init_run", busy_o, 1'b0);

    // Phase increment retune.
    phi_inc_i = 32'h0200_0000;
    run(60, 4);
    chk("phi_applied", phi_inc_o, 32'h0200_0000);

    // Out-of-range rate divider clamps; holding it stays in RUN.
    cfg_i[11:8] = 4'hF;
    run(60, 4);
    chk("clamp", cic_rate_div_o, 4'd5);
    run(20, 4);
    chk("no_retune", busy_o, 1'b0);

    // Abort after 3 settle samples, then change exactly when the counter hits 0.
    cfg_i[16:12] = 5'd7;
    wait_phase(P_SETTLE, S_SAMPLES - 3, "reach_settle3");
    cfg_i[16:12] = 5'd9;
    run(1, 4);
    chk("abort_mute", busy_o, 1'b1);
    wait_phase(P_SETTLE, 0, "reach_cnt0");
    cfg_i[21:17] = 5'd4;
    run(1, 4);
    chk("abort_prio", 64'(m_ph), 64'(P_MUTE));
    run(60, 4);

    // Reset in the middle of settling.
    phi_inc_i = 32'h0300_0000;
    wait_phase(P_SETTLE, 4, "reach_mid");
    reset = 1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 0;
    run(60, 4);

    // Random traffic with occasional retunes and resets.
    for (int i = 0; i < 3000; i++) begin
      sample_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) cfg_i[21:8] = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 4'($urandom)};
      if ($urandom_range(0, 79) == 0) phi_inc_i = $urandom;
      if ($urandom_range(0, 999) == 0) begin
        @(negedge clk);
        reset = 1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 0;
      end
      sample_valid_i = $urandom_range(0, 1);
      sample_data_i  = $urandom;
      cfg_i[7:0]     = 8'($urandom);
      cycle();
    end

`ifdef RETUNE_DROP_CNT_EN
    // Saturation: keep retuning with valid high so every cycle drops a sample.
    sample_valid_i = 1;
    for (int i = 0; i < 70000; i++) begin
      phi_inc_i = phi_inc_i + 1;
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    chk("drop_sat", drop_cnt_o, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
